// File: rtl/seq_pkg.sv
// seq_pkg: state encoding and datapath widths shared by the sequence checker.
package seq_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  typedef enum logic [3:0] {
    S_IDLE    = 4'h0,
    S_PREP    = 4'h1,
    S_WAIT    = 4'h2,
    S_REG     = 4'h3,
    S_CMP     = 4'h4,
    S_NEXT    = 4'h5,
    S_WIN     = 4'hA,
    S_LOSE    = 4'hE,
    S_TIMEOUT = 4'hF
  } state_e;
endpackage

// File: rtl/press_edge_detector.sv
// press_edge_detector: one-cycle pulse when any button goes active after all were released.
module press_edge_detector
  import seq_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] buttons,
  output logic              press
);
  logic any_d, any_q;
  always_comb any_d = |buttons;
  always_ff @(posedge clock or negedge reset)
    if (!reset) any_q <= 1'b0;
    else        any_q <= any_d;
  assign press = any_d & ~any_q;
endmodule

// File: rtl/sequence_checker.sv
// sequence_checker: walks the sequence ROM and checks one button press per position.
// Optional per-press timeout is enabled by defining SEQ_TIMEOUT_EN.
module sequence_checker
  import seq_pkg::*;
#(
  parameter int SEQ_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] buttons,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              ready,
  output logic              win,
  output logic              lose,
  output logic              timeout,
  output logic [3:0]        dbg_state
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SEQ_LEN - 1);
  if (SEQ_LEN < 1 || SEQ_LEN > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("sequence_checker: SEQ_LEN must be 1..16 and TIMEOUT_CYCLES >= 1");
  end
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] play_q, play_d;
  logic              press, expired;
  press_edge_detector u_edge (
    .clock   (clock),
    .reset   (reset),
    .buttons (buttons),
    .press   (press)
  );
`ifdef SEQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
  // Any non-WAIT state clears the timer, so every entry to WAIT starts from zero.
  always_comb tmr_d = (state_q == S_WAIT) ? tmr_q + 1'b1 : '0;
  always_ff @(posedge clock or negedge reset)
    if (!reset) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  assign expired = tmr_q == TMR_W'(TIMEOUT_CYCLES - 1);
  assign timeout = state_q == S_TIMEOUT;
`else
  assign expired = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    play_d  = play_q;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE, S_TIMEOUT: state_d = start ? S_PREP : state_q;
      S_PREP: state_d = S_WAIT;
      S_WAIT: begin
        // A press on the expiry cycle takes priority over the timeout.
        state_d = press ? S_REG : expired ? S_TIMEOUT : S_WAIT;
        play_d  = press ? buttons : play_q;
      end
      S_REG:  state_d = S_CMP;
      S_CMP:  state_d = (play_q != rom_data) ? S_LOSE : (addr_q == LAST) ? S_WIN : S_NEXT;
      S_NEXT: begin
        state_d = S_WAIT;
        addr_d  = (addr_q == LAST) ? addr_q : addr_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_PREP) begin
      addr_d = '0;
      play_d = '0;
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      play_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      play_q  <= play_d;
    end
  assign rom_addr  = addr_q;
  assign win       = state_q == S_WIN;
  assign lose      = state_q == S_LOSE || state_q == S_TIMEOUT;
  assign ready     = win || lose;
  assign dbg_state = state_q;
endmodule
